// File: rtl/controle_escrita_banco_pkg.sv
// rtl/controle_escrita_banco_pkg.sv - shared widths and writeback entry type
package controle_escrita_banco_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Register 0 is hardwired, so writes aimed at it never raise the write enable.
    function automatic logic writes_reg(input logic [ADDR_W-1:0] r);
        return r != REG_ZERO;
    endfunction

endpackage

// File: rtl/fila_carga.sv
// rtl/fila_carga.sv - synchronous FIFO holding returned load data until writeback
module fila_carga
    import controle_escrita_banco_pkg::*;
#(
    parameter int LOAD_DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PTR_W = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;
    localparam int CNT_W = $clog2(LOAD_DEPTH + 1);

    wb_entry_t        slots [LOAD_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(LOAD_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = slots[rd_ptr];

    // Pointers wrap at LOAD_DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LOAD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/controle_escrita_banco.sv
// rtl/controle_escrita_banco.sv - register-file write arbiter with load scoreboard
module controle_escrita_banco
    import controle_escrita_banco_pkg::wb_entry_t, controle_escrita_banco_pkg::writes_reg;
#(
    parameter int DATA_W     = controle_escrita_banco_pkg::DATA_W,
    parameter int ADDR_W     = controle_escrita_banco_pkg::ADDR_W,
    parameter int LOAD_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_W-1:0]      alu_reg,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   issue_load,
    input  logic [ADDR_W-1:0]      issue_reg,
    output logic                   issue_ready,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_reg,
    input  logic [DATA_W-1:0]      mem_data,
    output logic [(2**ADDR_W)-1:0] busy,
    output logic                   regWrite,
    output logic [ADDR_W-1:0]      write_register,
    output logic [DATA_W-1:0]      write_data
);

    localparam int CNT_W = $clog2(LOAD_DEPTH + 1);

    wb_entry_t              mem_entry;
    wb_entry_t              head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   alu_fire;
    logic                   issue_fire;
    logic [CNT_W-1:0]       outstanding;
    logic [(2**ADDR_W)-1:0] busy_next;

    assign mem_entry = '{rd: mem_reg, data: mem_data};

    fila_carga #(
        .LOAD_DEPTH (LOAD_DEPTH)
    ) u_fila_carga (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (mem_entry),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head)
    );

    // Readiness depends only on FIFO occupancy, never on the ALU offer.
    assign mem_ready = !fifo_full;
    assign alu_ready = !fifo_full;
    assign fifo_push = mem_valid && !fifo_full;
    assign alu_fire  = alu_valid && !fifo_full;
    // A full FIFO takes the port so returning loads can never be starved out.
    assign fifo_pop  = !fifo_empty && (fifo_full || !alu_valid);

    assign issue_ready = (outstanding < CNT_W'(LOAD_DEPTH)) && !busy[issue_reg];
    assign issue_fire  = issue_load && issue_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({issue_fire, fifo_push})
                2'b10: begin
                    if (outstanding != CNT_W'(LOAD_DEPTH)) begin
                        outstanding <= outstanding + 1'b1;
                    end
                end
                2'b01: begin
                    if (outstanding != '0) begin
                        outstanding <= outstanding - 1'b1;
                    end
                end
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Clear follows the load's own writeback, so a busy bit spans issue to regWrite.
    always_comb begin
        busy_next = busy;
        if (fifo_pop) begin
            busy_next[head.rd] = 1'b0;
        end
        if (issue_fire && writes_reg(issue_reg)) begin
            busy_next[issue_reg] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regWrite       <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
        end else if (alu_fire) begin
            regWrite       <= writes_reg(alu_reg);
            write_register <= alu_reg;
            write_data     <= alu_data;
        end else if (fifo_pop) begin
            regWrite       <= writes_reg(head.rd);
            write_register <= head.rd;
            write_data     <= head.data;
        end else begin
            regWrite       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_controle_escrita_banco.sv
// tb/tb_controle_escrita_banco.sv - directed bench with behavioural writeback model
module tb_controle_escrita_banco;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int LOAD_DEPTH = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              alu_valid = 1'b0;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              issue_load = 1'b0;
    logic [ADDR_W-1:0] issue_reg = '0;
    logic              issue_ready;
    logic              mem_valid = 1'b0;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_reg = '0;
    logic [DATA_W-1:0] mem_data = '0;
    logic [31:0]       busy;
    logic              regWrite;
    logic [ADDR_W-1:0] write_register;
    logic [DATA_W-1:0] write_data;

    controle_escrita_banco #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .LOAD_DEPTH (LOAD_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_reg        (alu_reg),
        .alu_data       (alu_data),
        .issue_load     (issue_load),
        .issue_reg      (issue_reg),
        .issue_ready    (issue_ready),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_reg        (mem_reg),
        .mem_data       (mem_data),
        .busy           (busy),
        .regWrite       (regWrite),
        .write_register (write_register),
        .write_data     (write_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [ADDR_W+DATA_W-1:0] m_q [$];
    int                       m_outst;
    logic [31:0]              m_busy;
    logic                     m_we;
    logic [ADDR_W-1:0]        m_wr;
    logic [DATA_W-1:0]        m_wd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_outst = 0;
        m_busy  = '0;
        m_we    = 1'b0;
        m_wr    = '0;
        m_wd    = '0;
    endtask

    function automatic logic m_issue_ok();
        return (m_outst < LOAD_DEPTH) && !m_busy[issue_reg];
    endfunction

    task automatic model_step();
        logic full, alu_acc, take_head, push, inc;
        logic [ADDR_W+DATA_W-1:0] e;
        if (reset) begin
            model_reset();
            return;
        end
        full      = (m_q.size() == LOAD_DEPTH);
        alu_acc   = alu_valid && !full;
        take_head = (m_q.size() != 0) && (full || !alu_valid);
        push      = mem_valid && !full;
        inc       = issue_load && m_issue_ok();
        if (alu_acc) begin
            m_we = (alu_reg != 0);
            m_wr = alu_reg;
            m_wd = alu_data;
        end else if (take_head) begin
            e = m_q.pop_front();
            m_wr = e[ADDR_W+DATA_W-1:DATA_W];
            m_wd = e[DATA_W-1:0];
            m_we = (m_wr != 0);
            m_busy[m_wr] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (push) m_q.push_back({mem_reg, mem_data});
        if (inc && issue_reg != 0) m_busy[issue_reg] = 1'b1;
        if (inc && !push && m_outst < LOAD_DEPTH) m_outst++;
        if (push && !inc && m_outst > 0) m_outst--;
    endtask

    // One clock cycle: check ready outputs, advance model, check registered outputs.
    task automatic tick();
        #1;
        chk("alu_ready", alu_ready, m_q.size() < LOAD_DEPTH);
        chk("mem_ready", mem_ready, m_q.size() < LOAD_DEPTH);
        chk("issue_ready", issue_ready, m_issue_ok());
        model_step();
        @(posedge clk);
        #1;
        chk("regWrite", regWrite, m_we);
        chk("busy", busy, m_busy);
        if (m_we) begin
            chk("write_register", write_register, m_wr);
            chk("write_data", write_data, m_wd);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        alu_valid  = 1'b0;
        issue_load = 1'b0;
        mem_valid  = 1'b0;
    endtask

    task automatic alu(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        alu_valid = 1'b1;
        alu_reg   = r;
        alu_data  = d;
    endtask

    task automatic mem(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        mem_valid = 1'b1;
        mem_reg   = r;
        mem_data  = d;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] r);
        issue_load = 1'b1;
        issue_reg  = r;
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b1;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_regWrite", regWrite, 0);
        chk("rst_write_register", write_register, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_busy", busy, 0);

        alu(8, 32'h0000_0007);
        tick();
        chk("t1_we", regWrite, 1);
        chk("t1_reg", write_register, 8);
        chk("t1_data", write_data, 7);
        idle();
        tick();
        chk("t1_we_drop", regWrite, 0);

        alu(0, 32'hFFFF_FFFF);
        #1 chk("t2_alu_ready", alu_ready, 1);
        tick();
        chk("t2_we_r0", regWrite, 0);
        idle();

        mem(6, 32'h66);
        tick();
        idle();
        tick();
        chk("pv_we", regWrite, 1);
        chk("pv_reg", write_register, 6);

        issue(5);
        tick();
        chk("t3_busy_set", busy[5], 1);
        idle();
        tick();
        mem(5, 32'h1234);
        issue(5);
        #1 chk("t3_reissue_blocked", issue_ready, 0);
        tick();
        chk("t3_busy_hold", busy[5], 1);
        idle();
        tick();
        chk("t3_we", regWrite, 1);
        chk("t3_reg", write_register, 5);
        chk("t3_data", write_data, 32'h1234);
        chk("t3_busy_clr", busy[5], 0);

        issue(3);
        tick();
        issue(4);
        tick();
        issue(9);
        #1 chk("t4_issue_full", issue_ready, 0);
        idle();
        alu(10, 32'hA0);
        mem(3, 32'h33);
        tick();
        alu(11, 32'hA1);
        mem(4, 32'h44);
        tick();
        mem_valid = 1'b0;
        alu(12, 32'hA2);
        #1 chk("t4_alu_stall", alu_ready, 0);
        chk("t4_mem_stall", mem_ready, 0);
        tick();
        chk("t4_head3", write_register, 3);
        chk("t4_head3_data", write_data, 32'h33);
        tick();
        chk("t4_alu12", write_register, 12);
        idle();
        tick();
        chk("t4_head4", write_register, 4);
        chk("t4_busy_clear", busy, 0);

        issue(3);
        tick();
        idle();
        mem(3, 32'hAB);
        alu(7, 32'h77);
        tick();
        chk("t5_busy3", busy[3], 1);
        idle();
        reset = 1'b1;
        model_reset();
        #1 chk("t5_rst_we", regWrite, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_reg", write_register, 0);
        chk("t5_rst_mem_ready", mem_ready, 1);
        tick();
        reset = 1'b0;
        tick();
        chk("t5_no_stray", regWrite, 0);
        tick();
        chk("t5_no_stray2", regWrite, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
